// File: rtl/lpg_pkg.sv
// rtl/lpg_pkg.sv - shared state encoding and default sizes for the looping pattern generator
package lpg_pkg;

   // Controller states: IDLE accepts pattern writes and capture reads, RUN plays the pattern
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } lpg_state_e;

   localparam int LPG_NUM_SIG  = 8;
   localparam int LPG_NUM_SAMP = 128;
   localparam int LPG_DIV_W    = 16;
   localparam int LPG_LOOP_W   = 16;

endpackage

// File: rtl/lpg_sample_ram.sv
// rtl/lpg_sample_ram.sv - one-write/one-read synchronous sample RAM with held read data
module lpg_sample_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 128,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Storage array: contents survive reset
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end

   // Read register only updates on a read request, otherwise it holds its value
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_o <= '0;
      end else if (re_i) begin
         rdata_o <= mem[raddr_i];
      end
   end

endmodule

// File: rtl/looping_pattern_generator.sv
// rtl/looping_pattern_generator.sv - plays a stored pattern with per-step input capture and looping
module looping_pattern_generator
   import lpg_pkg::*;
#(
   parameter int NUM_SIG  = LPG_NUM_SIG,
   parameter int NUM_SAMP = LPG_NUM_SAMP,
   parameter int DIV_W    = LPG_DIV_W,
   parameter int LOOP_W   = LPG_LOOP_W
) (
   input  logic               axi_clk,
   input  logic               axi_reset,
   input  logic               run,
   input  logic               abort,
   input  logic [DIV_W-1:0]   clk_div,
   input  logic [LOOP_W-1:0]  loop_count,
   input  logic               wr_clear,
   input  logic [NUM_SIG-1:0] write_channel,
   input  logic               write_channel_wrStrobe,
   output logic [NUM_SIG-1:0] read_channel,
   input  logic               read_channel_rdStrobe,
   output logic               read_channel_valid,
   output logic [NUM_SIG-1:0] output_signals,
   input  logic [NUM_SIG-1:0] input_signals,
   output logic               busy,
   output logic               done,
   output logic               wr_full,
   output logic               rd_empty
);

   localparam int AW = (NUM_SAMP > 1) ? $clog2(NUM_SAMP) : 1;
   localparam int PW = $clog2(NUM_SAMP + 1);

   lpg_state_e         state_q;
   logic [PW-1:0]      wr_ptr_q;
   logic [PW-1:0]      rd_ptr_q;
   logic [PW-1:0]      cap_cnt_q;
   logic [PW-1:0]      len_q;
   logic [PW-1:0]      step_q;
   logic [DIV_W-1:0]   div_q;
   logic [DIV_W-1:0]   div_cnt_q;
   logic [LOOP_W-1:0]  loops_q;
   logic [LOOP_W-1:0]  pass_q;
   logic               first_q;
   logic [NUM_SIG-1:0] out_q;
   logic               valid_q;
   logic               done_q;

   logic               start;
   logic               step_end;
   logic               last_step;
   logic               final_pass;
   logic               full_w;
   logic [PW-1:0]      step_d;
   logic [PW-1:0]      nxt_idx;
   logic               pat_we;
   logic               pat_re;
   logic [AW-1:0]      pat_raddr;
   logic [NUM_SIG-1:0] pat_rdata;
   logic               cap_we;
   logic               cap_re;

   // Step sequencing decisions; the pattern RAM is always read one step ahead so
   // its held read data is the value to drive at the next step boundary
   always_comb begin
      full_w     = (wr_ptr_q == PW'(NUM_SAMP));
      start      = (state_q == ST_IDLE) && run && !abort && (wr_ptr_q != '0);
      step_end   = (state_q == ST_RUN) && !first_q && (div_cnt_q == div_q);
      last_step  = (step_q == len_q - PW'(1));
      final_pass = (loops_q != '0) && (pass_q == loops_q - LOOP_W'(1));
      step_d     = (first_q || last_step) ? '0 : step_q + PW'(1);
      nxt_idx    = (step_d == len_q - PW'(1)) ? '0 : step_d + PW'(1);
      pat_re     = start ||
                   ((state_q == ST_RUN) && !abort &&
                    (first_q || (step_end && !(last_step && final_pass))));
      pat_raddr  = start ? '0 : AW'(nxt_idx);
      pat_we     = (state_q == ST_IDLE) && write_channel_wrStrobe && !wr_clear &&
                   !full_w && !axi_reset;
      cap_we     = step_end && !abort && !axi_reset;
      cap_re     = (state_q == ST_IDLE) && read_channel_rdStrobe && (rd_ptr_q != cap_cnt_q);
   end

   lpg_sample_ram #(.WIDTH(NUM_SIG), .DEPTH(NUM_SAMP), .AW(AW)) u_pattern_ram (
      .clk_i   (axi_clk),
      .rst_i   (axi_reset),
      .we_i    (pat_we),
      .waddr_i (AW'(wr_ptr_q)),
      .wdata_i (write_channel),
      .re_i    (pat_re),
      .raddr_i (pat_raddr),
      .rdata_o (pat_rdata)
   );

   lpg_sample_ram #(.WIDTH(NUM_SIG), .DEPTH(NUM_SAMP), .AW(AW)) u_capture_ram (
      .clk_i   (axi_clk),
      .rst_i   (axi_reset),
      .we_i    (cap_we),
      .waddr_i (AW'(step_q)),
      .wdata_i (input_signals),
      .re_i    (cap_re),
      .raddr_i (AW'(rd_ptr_q)),
      .rdata_o (read_channel)
   );

   // Controller: pointer management in IDLE, step/loop timing in RUN
   always_ff @(posedge axi_clk) begin
      if (axi_reset) begin
         state_q   <= ST_IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cap_cnt_q <= '0;
         len_q     <= '0;
         step_q    <= '0;
         div_q     <= '0;
         div_cnt_q <= '0;
         loops_q   <= '0;
         pass_q    <= '0;
         first_q   <= 1'b0;
         out_q     <= '0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               valid_q <= cap_re;
               if (cap_re) begin
                  rd_ptr_q <= rd_ptr_q + PW'(1);
               end
               if (wr_clear) begin
                  wr_ptr_q <= '0;
               end else if (pat_we) begin
                  wr_ptr_q <= wr_ptr_q + PW'(1);
               end
               if (start) begin
                  state_q   <= ST_RUN;
                  len_q     <= wr_ptr_q;
                  div_q     <= clk_div;
                  loops_q   <= loop_count;
                  pass_q    <= '0;
                  step_q    <= '0;
                  div_cnt_q <= '0;
                  first_q   <= 1'b1;
                  cap_cnt_q <= '0;
                  rd_ptr_q  <= '0;
               end
            end
            ST_RUN: begin
               valid_q <= 1'b0;
               if (abort) begin
                  state_q <= ST_IDLE;
                  out_q   <= '0;
                  first_q <= 1'b0;
               end else if (first_q) begin
                  out_q     <= pat_rdata;
                  first_q   <= 1'b0;
                  step_q    <= '0;
                  div_cnt_q <= '0;
               end else if (step_end) begin
                  div_cnt_q <= '0;
                  if (cap_cnt_q != len_q) begin
                     cap_cnt_q <= cap_cnt_q + PW'(1);
                  end
                  if (last_step && final_pass) begin
                     out_q   <= '0;
                     done_q  <= 1'b1;
                     state_q <= ST_IDLE;
                  end else begin
                     out_q  <= pat_rdata;
                     step_q <= step_d;
                     if (last_step) begin
                        pass_q <= pass_q + LOOP_W'(1);
                     end
                  end
               end else begin
                  div_cnt_q <= div_cnt_q + DIV_W'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign output_signals     = out_q;
   assign read_channel_valid = valid_q;
   assign done               = done_q;
   assign busy               = (state_q == ST_RUN);
   assign wr_full            = full_w;
   assign rd_empty           = (rd_ptr_q == cap_cnt_q);

endmodule

// File: tb/tb_looping_pattern_generator.sv
// tb/tb_looping_pattern_generator.sv - directed self-checking bench for looping_pattern_generator
module tb_looping_pattern_generator;

   logic        axi_clk = 1'b0;
   logic        axi_reset = 1'b1;
   logic        run = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] clk_div = '0;
   logic [15:0] loop_count = '0;
   logic        wr_clear = 1'b0;
   logic [7:0]  write_channel = '0;
   logic        write_channel_wrStrobe = 1'b0;
   logic [7:0]  read_channel;
   logic        read_channel_rdStrobe = 1'b0;
   logic        read_channel_valid;
   logic [7:0]  output_signals;
   logic [7:0]  input_signals = '0;
   logic        busy;
   logic        done;
   logic        wr_full;
   logic        rd_empty;

   int checks = 0;
   int fails  = 0;

   looping_pattern_generator dut (
      .axi_clk                (axi_clk),
      .axi_reset              (axi_reset),
      .run                    (run),
      .abort                  (abort),
      .clk_div                (clk_div),
      .loop_count             (loop_count),
      .wr_clear               (wr_clear),
      .write_channel          (write_channel),
      .write_channel_wrStrobe (write_channel_wrStrobe),
      .read_channel           (read_channel),
      .read_channel_rdStrobe  (read_channel_rdStrobe),
      .read_channel_valid     (read_channel_valid),
      .output_signals         (output_signals),
      .input_signals          (input_signals),
      .busy                   (busy),
      .done                   (done),
      .wr_full                (wr_full),
      .rd_empty               (rd_empty)
   );

   always #5 axi_clk = ~axi_clk;

   task automatic tick();
      @(negedge axi_clk);
   endtask

   task automatic wr_word(input logic [7:0] v);
      write_channel          = v;
      write_channel_wrStrobe = 1'b1;
      tick();
      write_channel_wrStrobe = 1'b0;
   endtask

   task automatic clear_ptr();
      wr_clear = 1'b1;
      tick();
      wr_clear = 1'b0;
   endtask

   task automatic pulse_run();
      run = 1'b1;
      tick();
      run = 1'b0;
   endtask

   task automatic test_reset();
      axi_reset = 1'b1;
      tick();
      tick();
      checks++;
      if ({output_signals, read_channel, read_channel_valid, busy, done, wr_full, rd_empty}
          !== {8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         $display("FAIL reset_values got out=%h rc=%h v=%b busy=%b done=%b full=%b empty=%b",
                  output_signals, read_channel, read_channel_valid, busy, done, wr_full, rd_empty);
         fails++;
      end
      axi_reset = 1'b0;
      tick();
   endtask

   task automatic test_ramp();
      logic [7:0] pat [6] = '{8'd1, 8'd3, 8'd7, 8'd15, 8'd31, 8'd63};
      logic [7:0] ins [6] = '{8'd42, 8'd85, 8'd42, 8'd85, 8'd0, 8'd127};
      clear_ptr();
      for (int i = 0; i < 6; i++) wr_word(pat[i]);
      clk_div    = 16'd99;
      loop_count = 16'd1;
      pulse_run();
      checks++;
      if (busy !== 1'b1) begin
         $display("FAIL ramp_busy got %b want 1", busy);
         fails++;
      end
      for (int k = 0; k < 6; k++) begin
         for (int c = 0; c < 100; c++) begin
            tick();
            if (c == 0) input_signals = ins[k];
            if (c == 0 || c == 99) begin
               checks++;
               if (output_signals !== pat[k]) begin
                  $display("FAIL ramp_out step %0d cyc %0d got %0d want %0d", k, c, output_signals, pat[k]);
                  fails++;
               end
            end
         end
      end
      tick();
      checks++;
      if ({output_signals, done, busy} !== {8'h00, 1'b1, 1'b0}) begin
         $display("FAIL ramp_done got out=%0d done=%b busy=%b want 0 1 0", output_signals, done, busy);
         fails++;
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         $display("FAIL ramp_done_pulse got %b want 0", done);
         fails++;
      end
      read_channel_rdStrobe = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++;
         if ({read_channel_valid, read_channel} !== {1'b1, ins[k]}) begin
            $display("FAIL ramp_read %0d got v=%b d=%0d want 1 %0d", k, read_channel_valid, read_channel, ins[k]);
            fails++;
         end
      end
      tick();
      read_channel_rdStrobe = 1'b0;
      checks++;
      if ({read_channel_valid, read_channel, rd_empty} !== {1'b0, 8'd127, 1'b1}) begin
         $display("FAIL ramp_empty got v=%b d=%0d e=%b want 0 127 1", read_channel_valid, read_channel, rd_empty);
         fails++;
      end
   endtask

   task automatic test_looping();
      logic [7:0] exp [6] = '{8'd5, 8'd10, 8'd5, 8'd10, 8'd5, 8'd10};
      clear_ptr();
      wr_word(8'd5);
      wr_word(8'd10);
      clk_div    = 16'd0;
      loop_count = 16'd3;
      pulse_run();
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if ({output_signals, done} !== {exp[i], 1'b0}) begin
            $display("FAIL loop_out %0d got %0d done=%b want %0d 0", i, output_signals, done, exp[i]);
            fails++;
         end
      end
      tick();
      checks++;
      if ({output_signals, done, busy} !== {8'h00, 1'b1, 1'b0}) begin
         $display("FAIL loop_done got out=%0d done=%b busy=%b want 0 1 0", output_signals, done, busy);
         fails++;
      end
      loop_count = 16'd1;
      pulse_run();
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (output_signals !== exp[i]) begin
            $display("FAIL replay_out %0d got %0d want %0d", i, output_signals, exp[i]);
            fails++;
         end
      end
      tick();
      checks++;
      if (done !== 1'b1) begin
         $display("FAIL replay_done got %b want 1", done);
         fails++;
      end
   endtask

   task automatic test_abort();
      clear_ptr();
      for (int i = 1; i <= 4; i++) wr_word(8'(i));
      clk_div    = 16'd9;
      loop_count = 16'd0;
      pulse_run();
      for (int c = 1; c <= 25; c++) begin
         tick();
         if (c == 1)  input_signals = 8'h11;
         if (c == 11) input_signals = 8'h22;
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if ({output_signals, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
         $display("FAIL abort_stop got out=%0d busy=%b done=%b want 0 0 0", output_signals, busy, done);
         fails++;
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (done !== 1'b0) begin
            $display("FAIL abort_no_done got %b want 0", done);
            fails++;
         end
      end
      read_channel_rdStrobe = 1'b1;
      tick();
      checks++;
      if ({read_channel_valid, read_channel} !== {1'b1, 8'h11}) begin
         $display("FAIL abort_read0 got v=%b d=%h want 1 11", read_channel_valid, read_channel);
         fails++;
      end
      tick();
      checks++;
      if ({read_channel_valid, read_channel, rd_empty} !== {1'b1, 8'h22, 1'b1}) begin
         $display("FAIL abort_read1 got v=%b d=%h e=%b want 1 22 1", read_channel_valid, read_channel, rd_empty);
         fails++;
      end
      tick();
      read_channel_rdStrobe = 1'b0;
      checks++;
      if ({read_channel_valid, read_channel} !== {1'b0, 8'h22}) begin
         $display("FAIL abort_cap_count got v=%b d=%h want 0 22", read_channel_valid, read_channel);
         fails++;
      end
   endtask

   task automatic test_full();
      clear_ptr();
      for (int i = 0; i < 130; i++) begin
         wr_word(8'(i));
         if (i == 126 || i == 127) begin
            checks++;
            if (wr_full !== (i == 127)) begin
               $display("FAIL full_flag after %0d writes got %b want %b", i + 1, wr_full, (i == 127));
               fails++;
            end
         end
      end
      clk_div    = 16'd0;
      loop_count = 16'd1;
      pulse_run();
      for (int i = 0; i < 128; i++) begin
         tick();
         checks++;
         if (output_signals !== 8'(i)) begin
            $display("FAIL full_play %0d got %0d want %0d", i, output_signals, i);
            fails++;
         end
      end
      tick();
      checks++;
      if ({output_signals, done} !== {8'h00, 1'b1}) begin
         $display("FAIL full_done got out=%0d done=%b want 0 1", output_signals, done);
         fails++;
      end
   endtask

   task automatic test_edge_cases();
      clear_ptr();
      pulse_run();
      checks++;
      if (busy !== 1'b0) begin
         $display("FAIL run_empty got busy=%b want 0", busy);
         fails++;
      end
      wr_word(8'hA1);
      wr_word(8'hB2);
      run   = 1'b1;
      abort = 1'b1;
      tick();
      run   = 1'b0;
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         $display("FAIL run_abort_same got busy=%b want 0", busy);
         fails++;
      end
      clk_div    = 16'd3;
      loop_count = 16'd0;
      pulse_run();
      read_channel_rdStrobe = 1'b1;
      tick();
      tick();
      read_channel_rdStrobe = 1'b0;
      checks++;
      if ({busy, read_channel_valid, read_channel, output_signals} !== {1'b1, 1'b0, 8'h22, 8'hA1}) begin
         $display("FAIL rd_in_run got busy=%b v=%b d=%h out=%h want 1 0 22 a1",
                  busy, read_channel_valid, read_channel, output_signals);
         fails++;
      end
      for (int i = 0; i < 5; i++) tick();
      axi_reset = 1'b1;
      tick();
      checks++;
      if ({output_signals, read_channel, read_channel_valid, busy, done, wr_full, rd_empty}
          !== {8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         $display("FAIL reset_mid_run got out=%h rc=%h v=%b busy=%b done=%b full=%b empty=%b",
                  output_signals, read_channel, read_channel_valid, busy, done, wr_full, rd_empty);
         fails++;
      end
      axi_reset = 1'b0;
      tick();
      pulse_run();
      checks++;
      if (busy !== 1'b0) begin
         $display("FAIL reset_clears_ptr got busy=%b want 0", busy);
         fails++;
      end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_looping();
      test_abort();
      test_full();
      test_edge_cases();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
